// File: rtl/scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : scan_pkg                                               |
// | Description : Shared types and helpers for the anode scan controller |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 4;

    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

    // Active-low select for one digit: exactly one bit cleared
    function automatic logic [NUM_DIGITS-1:0] onecold_anode(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_pwm_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : seg_pwm_gen                                            |
// | Description : Free-running PWM counter with level compare; active    |
// |               while the count is below the requested level          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module seg_pwm_gen #(
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_clear,
    input  logic                i_enable,
    input  logic [PWM_BITS-1:0] i_level,
    output logic                o_active
);

    logic [PWM_BITS-1:0] r_cnt;

    // Counter held at zero while cleared, so the first enabled cycle sees 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + PWM_BITS'(1);
        end
    end

    // Level 0 never matches; full-scale level leaves one dark count per period
    assign o_active = (r_cnt < i_level);

endmodule
`default_nettype wire

// File: rtl/anode_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : anode_scanner                                          |
// | Description : 4-digit seven-segment scan controller. Rotates an      |
// |               active-low one-cold anode with blanking, per-digit     |
// |               mask, PWM brightness and a frame pulse.                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module anode_scanner
    import scan_pkg::*;
#(
    parameter int DIGIT_TICKS = 100000,
    parameter int BLANK_TICKS = 1000,
    parameter int PWM_BITS    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic [NUM_DIGITS-1:0] i_digit_mask,
    input  logic [PWM_BITS-1:0]   i_brightness,
    output logic [NUM_DIGITS-1:0] o_anode,
    output logic [1:0]            o_digit_idx,
    output logic                  o_frame_tick
);

    localparam int                 c_CNT_W      = $clog2(DIGIT_TICKS);
    localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(BLANK_TICKS - 1);
    localparam logic [c_CNT_W-1:0] c_SLOT_LAST  = c_CNT_W'(DIGIT_TICKS - 1);
    localparam logic [1:0]         c_LAST_DIGIT = 2'(NUM_DIGITS - 1);

    generate
        if ((BLANK_TICKS < 1) || (BLANK_TICKS >= DIGIT_TICKS)) begin : g_param_check
            $error("anode_scanner: need 1 <= BLANK_TICKS < DIGIT_TICKS");
        end
    endgenerate

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic [1:0]            r_idx;
    logic [1:0]            w_idx_nxt;
    logic                  w_load_shadow;
    logic                  w_frame_nxt;
    logic [NUM_DIGITS-1:0] r_mask;
    logic [PWM_BITS-1:0]   r_bright;
    logic                  w_pwm_active;
    logic [NUM_DIGITS-1:0] w_anode_nxt;
    logic [NUM_DIGITS-1:0] r_anode;
    logic [1:0]            r_digit_idx;
    logic                  r_frame;
    logic                  w_blank_last;
    logic                  w_slot_last;

    assign w_blank_last = (r_cnt == c_BLANK_LAST);
    assign w_slot_last  = (r_cnt == c_SLOT_LAST);

    // Scan state, slot-cycle counter and current digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic; dropping enable overrides everything, including slot end
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_load_shadow = 1'b0;
        w_frame_nxt   = 1'b0;
        if (!i_en) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt   = BLANK;
                    w_cnt_nxt     = '0;
                    w_idx_nxt     = 2'd0;
                    w_load_shadow = 1'b1;
                end
                BLANK: begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    if (w_blank_last) begin
                        w_state_nxt = DRIVE;
                    end
                end
                DRIVE: begin
                    if (w_slot_last) begin
                        w_state_nxt   = BLANK;
                        w_cnt_nxt     = '0;
                        w_idx_nxt     = r_idx + 2'd1;
                        w_load_shadow = 1'b1;
                        w_frame_nxt   = (r_idx == c_LAST_DIGIT);
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 2'd0;
                end
            endcase
        end
    end

    // Mask and brightness are frozen for a whole slot, sampled as it begins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask   <= '0;
            r_bright <= '0;
        end else if (w_load_shadow) begin
            r_mask   <= i_digit_mask;
            r_bright <= i_brightness;
        end
    end

    seg_pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (r_state != DRIVE),
        .i_enable (r_state == DRIVE),
        .i_level  (r_bright),
        .o_active (w_pwm_active)
    );

    // Anode is only ever driven during DRIVE, so blanking is guaranteed
    always_comb begin
        w_anode_nxt = ANODE_OFF;
        if (i_en && (r_state == DRIVE) && r_mask[r_idx] && w_pwm_active) begin
            w_anode_nxt = onecold_anode(r_idx);
        end
    end

    // Registered outputs keep the anode glitch-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_anode     <= ANODE_OFF;
            r_digit_idx <= 2'd0;
            r_frame     <= 1'b0;
        end else begin
            r_anode     <= w_anode_nxt;
            r_digit_idx <= i_en ? r_idx : 2'd0;
            r_frame     <= w_frame_nxt;
        end
    end

    assign o_anode      = r_anode;
    assign o_digit_idx  = r_digit_idx;
    assign o_frame_tick = r_frame;

endmodule
`default_nettype wire

// File: doc/anode_scanner.md
Name: anode_scanner

Overview:
Time-multiplexing scan controller for the 4-digit seven-segment display. Generates the rotating active-low, one-cold anode pattern that the segment decoder stage consumes to select its digit value. It also provides:
- anti-ghosting blank time between digits
- per-digit blanking mask
- PWM brightness control
- a frame pulse for upstream logic

Parameters:
DIGIT_TICKS, 100000, clock cycles per digit slot (blank + drive); 1 kHz/digit at 100 MHz
BLANK_TICKS, 1000, cycles at the start of each slot with all anodes off; legal range 1 <= BLANK_TICKS < DIGIT_TICKS, otherwise elaboration error
PWM_BITS, 4, width of brightness input and PWM counter

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock, asynchronous assert, active-low
en  in  1  scan enable; 0 = display dark, scanner idle
digit_mask  in  4  bit i = 1 shows digit i; 0 keeps it dark for its slot
brightness  in  PWM_BITS  drive duty; 0 = off, 2^PWM_BITS-1 = max
anode  out  4  active-low one-cold anode select; 4'b1111 = all off
digit_idx  out  2  index of the slot currently in progress
frame_tick  out  1  one-cycle pulse on the last cycle of the digit-3 slot

Behaviour:
- Reset (async, rst_n=0): state=IDLE, anode=4'b1111, digit_idx=0, frame_tick=0, slot and PWM counters 0. Outputs go to these values immediately, with no clock edge required.
- All outputs are registered; anode never glitches.
- Slot-to-anode mapping: 0->1110, 1->1101, 2->1011, 3->0111.
- Scan order: 0,1,2,3, then wraps to 0.
- States:
  - IDLE -> BLANK when en=1. Slot counter clears, digit_idx=0.
  - BLANK lasts BLANK_TICKS cycles, anode=1111. Transitions to DRIVE.
  - DRIVE lasts DIGIT_TICKS-BLANK_TICKS cycles. On its last cycle: digit_idx increments (mod 4) and state returns to BLANK.
- Slot timing: slot cycle c runs 0..DIGIT_TICKS-1 from BLANK entry; anode reflects c one cycle after the counter (registered).
- Mask/brightness sampling:
  - digit_mask and brightness are captured into shadow registers on BLANK entry.
  - Changes mid-slot take effect at the next slot.
- PWM:
  - pwm_cnt (PWM_BITS wide) clears on DRIVE entry, increments every DRIVE cycle, wraps naturally.
  - The digit anode is active iff mask_shadow[digit_idx]=1 and pwm_cnt < brightness_shadow.
  - Duty is brightness/2^PWM_BITS; max brightness gives (2^PWM_BITS-1)/2^PWM_BITS.
- Masked or zero-brightness slots still consume full slot time, so the frame period is constant at 4*DIGIT_TICKS.
- frame_tick asserts for exactly one cycle, on the final DRIVE cycle of digit 3. It also asserts when all digits are masked.
- en deasserted in any state: next edge goes to IDLE, anode=1111, digit_idx=0, frame_tick=0. Re-enable always restarts at digit 0 BLANK.
- Simultaneous en fall and slot end: en wins; frame_tick does not pulse.
- Only one anode bit is ever low; a low bit never coincides with BLANK.

Decomposition:
- Package scan_pkg holds:
  - state enum {IDLE, BLANK, DRIVE}
  - NUM_DIGITS=4
  - ANODE_OFF=4'b1111
  - function onecold_anode(idx) returning ~(4'b0001 << idx)
- One sub-module, seg_pwm_gen: PWM counter plus compare, with clear/enable inputs and an active output.
- Slot counter and FSM stay in anode_scanner.

Test Plan:
1. DIGIT_TICKS=8, BLANK_TICKS=2, mask=1111, brightness=15, en=1 after reset -> each 8-cycle slot shows 2 cycles of 1111, then 6 cycles of 1110 / 1101 / 1011 / 0111 in order; frame_tick high only on cycle 31, then every 32 cycles.
2. Same timing, mask=0101 -> only 1110 and 1011 ever driven; slots 1 and 3 stay 1111 for all 8 cycles; frame_tick period stays 32.
3. DIGIT_TICKS=20, BLANK_TICKS=2, brightness=2 -> per slot the anode is active only at slot cycles 2,3 and 18,19 (pwm_cnt 0,1 after wrap); brightness=0 -> anode constantly 1111.
4. en dropped at slot-1 cycle 4 -> anode=1111 and digit_idx=0 next cycle, no frame_tick; en re-raised -> 2 blank cycles, then 1110.
5. rst_n pulsed low mid-DRIVE between clock edges -> anode=1111 and digit_idx=0 without a clock edge; after release, scanning resumes from IDLE per en.
6. brightness changed 15->0 at slot-2 cycle 3 -> slot 2 completes at full duty (1011 through cycle 7); slot 3 onward fully dark.
